// File: rtl/wb_arb_pkg.sv
// Shared types and width helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index n items (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of req in order ptr+1, ptr+2, ... (mod NREQ).
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    // Walk from the farthest slot back to the nearest so the nearest set bit wins.
    always_comb begin
        grant_idx = '0;
        any       = |req;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                grant_idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-way round-robin arbiter sharing one pipelined Wishbone client port,
// with per-owner outstanding tracking and an ack watchdog.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NREQ             = 4,
    parameter int AW               = 32,
    parameter int DW               = 32,
    parameter int TIMEOUT          = 255,
    parameter int MAXOUT           = 15,
    parameter bit OPT_ZERO_ON_IDLE = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_cyc,
    input  logic [NREQ-1:0]         req_stb,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ*DW/8-1:0]    req_sel,
    output logic [NREQ-1:0]         req_ack,
    output logic [NREQ-1:0]         req_err,
    output logic [NREQ-1:0]         req_stall,
    output logic                    o_cyc,
    output logic                    o_stb,
    output logic                    o_we,
    output logic [AW-1:0]           o_addr,
    output logic [DW-1:0]           o_data,
    output logic [DW/8-1:0]         o_sel,
    input  logic                    o_ack,
    input  logic                    o_err,
    input  logic                    o_stall,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = DW / 8;
    localparam int OW = cnt_w(MAXOUT);
    localparam int WW = cnt_w(TIMEOUT);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;
    logic [OW-1:0]   r_outst;
    logic [WW-1:0]   r_wdog;

    logic [IW-1:0]   w_pick;
    logic            w_any;
    logic            w_busy;
    logic            w_own_cyc;
    logic            w_full;
    logic            w_empty;
    logic            w_stb;
    logic            w_accept;
    logic            w_fwd_ack;
    logic            w_fwd_err;
    logic            w_resp;
    logic            w_timeout;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req       (req_cyc),
        .ptr       (r_ptr),
        .grant_idx (w_pick),
        .any       (w_any)
    );

    assign w_busy    = (r_state == BUSY);
    assign w_own_cyc = req_cyc[r_owner];
    assign w_full    = (r_outst == OW'(MAXOUT));
    assign w_empty   = (r_outst == '0);
    // Strobe is gated by the owner's cyc so a dropping owner never issues a request.
    assign w_stb     = w_busy && w_own_cyc && req_stb[r_owner] && !w_full;
    assign w_accept  = w_stb && !o_stall;
    assign w_fwd_ack = w_busy && o_ack && !w_empty;
    assign w_fwd_err = w_busy && o_err && !w_empty;
    assign w_resp    = w_fwd_ack || w_fwd_err;
    assign w_timeout = (TIMEOUT != 0) && (r_wdog == WW'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = BUSY;
            BUSY: begin
                if (!w_own_cyc)     w_state_nxt = IDLE;
                else if (w_timeout) w_state_nxt = ABORT;
            end
            ABORT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_ptr   <= IW'(NREQ - 1);
            r_owner <= '0;
            r_outst <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any) begin
                r_owner <= w_pick;
                r_ptr   <= w_pick;
            end
            // Counters only live while the owner keeps the bus; any exit clears them.
            if (w_busy && w_state_nxt == BUSY) begin
                case ({w_accept, w_resp})
                    2'b10:   r_outst <= r_outst + OW'(1);
                    2'b01:   r_outst <= r_outst - OW'(1);
                    default: r_outst <= r_outst;
                endcase
                if (w_resp || w_empty || TIMEOUT == 0) r_wdog <= '0;
                else                                  r_wdog <= r_wdog + WW'(1);
            end else begin
                r_outst <= '0;
                r_wdog  <= '0;
            end
        end
    end

    always_comb begin
        o_cyc     = 1'b0;
        o_stb     = 1'b0;
        o_we      = 1'b0;
        o_addr    = '0;
        o_data    = '0;
        o_sel     = '0;
        req_stall = '1;
        req_ack   = '0;
        req_err   = '0;
        case (r_state)
            BUSY: begin
                o_cyc              = w_own_cyc;
                o_stb              = w_stb;
                req_stall[r_owner] = o_stall || w_full;
                req_ack[r_owner]   = w_fwd_ack;
                req_err[r_owner]   = w_fwd_err;
            end
            ABORT:   req_err[r_owner] = 1'b1;
            default: ;
        endcase
        if (!OPT_ZERO_ON_IDLE || w_stb) begin
            o_we   = req_we[r_owner];
            o_addr = req_addr[r_owner*AW +: AW];
            o_data = req_data[r_owner*DW +: DW];
            o_sel  = req_sel[r_owner*SW +: SW];
        end
    end

    assign owner = r_owner;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Cycle-by-cycle vector bench for wb_rr_arbiter (NREQ=4, MAXOUT=3, TIMEOUT=8).
module tb_wb_rr_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 8;
    localparam int MAXOUT  = 3;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ-1:0]      req_cyc, req_stb, req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ*SW-1:0]   req_sel;
    logic [NREQ-1:0]      req_ack, req_err, req_stall;
    logic                 o_cyc, o_stb, o_we;
    logic [AW-1:0]        o_addr;
    logic [DW-1:0]        o_data;
    logic [SW-1:0]        o_sel;
    logic                 o_ack, o_err, o_stall;
    logic [1:0]           owner;

    always #5 CLK = ~CLK;

    wb_rr_arbiter #(
        .NREQ             (NREQ),
        .AW               (AW),
        .DW               (DW),
        .TIMEOUT          (TIMEOUT),
        .MAXOUT           (MAXOUT),
        .OPT_ZERO_ON_IDLE (1'b1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_cyc   (req_cyc),
        .req_stb   (req_stb),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_sel   (req_sel),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .req_stall (req_stall),
        .o_cyc     (o_cyc),
        .o_stb     (o_stb),
        .o_we      (o_we),
        .o_addr    (o_addr),
        .o_data    (o_data),
        .o_sel     (o_sel),
        .o_ack     (o_ack),
        .o_err     (o_err),
        .o_stall   (o_stall),
        .owner     (owner)
    );

    typedef struct {
        logic       rst;
        logic [3:0] cyc;
        logic [3:0] stb;
        logic       ack;
        logic       err;
        logic       stall;
        logic       e_cyc;
        logic       e_stb;
        logic [3:0] e_ack;
        logic [3:0] e_err;
        logic [3:0] e_stall;
        int         e_own;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_no   = 0;

    function automatic vec_t mk(input logic rst, input logic [3:0] cyc, input logic [3:0] stb,
                                input logic ack, input logic err, input logic stall,
                                input logic ecyc, input logic estb, input logic [3:0] eack,
                                input logic [3:0] eerr, input logic [3:0] estall, input int eown);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.stall = stall;
        v.e_cyc = ecyc; v.e_stb = estb; v.e_ack = eack; v.e_err = eerr;
        v.e_stall = estall; v.e_own = eown;
        return v;
    endfunction

    function automatic logic [SW-1:0] sel_of(input int i);
        return SW'((i % 3) + 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec%0d %s: got %0h expected %0h", vec_no, name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
    task automatic apply(input vec_t v);
        vec_t e;
        RST     = v.rst;
        req_cyc = v.cyc;
        req_stb = v.stb;
        o_ack   = v.ack;
        o_err   = v.err;
        o_stall = v.stall;
        exp_q.push_back(v);
        @(negedge CLK);
        e = exp_q.pop_front();
        chk("o_cyc", 32'(o_cyc), 32'(e.e_cyc));
        chk("o_stb", 32'(o_stb), 32'(e.e_stb));
        chk("req_ack", 32'(req_ack), 32'(e.e_ack));
        chk("req_err", 32'(req_err), 32'(e.e_err));
        chk("req_stall", 32'(req_stall), 32'(e.e_stall));
        if (e.e_own >= 0) chk("owner", 32'(owner), 32'(e.e_own));
        if (e.e_stb && e.e_own >= 0) begin
            chk("o_addr", 32'(o_addr), 32'(16'hA000 + 16'(e.e_own)));
            chk("o_data", 32'(o_data), 32'(16'hD000 + 16'(e.e_own)));
            chk("o_sel", 32'(o_sel), 32'(sel_of(e.e_own)));
            chk("o_we", 32'(o_we), 32'(e.e_own % 2));
        end else begin
            chk("o_addr_idle", 32'(o_addr), 32'h0);
            chk("o_data_idle", 32'(o_data), 32'h0);
        end
        vec_no++;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int ord[5];
        logic [3:0] m;
        ord = '{0, 1, 2, 3, 0};

        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = 16'hA000 + 16'(i);
            req_data[i*DW +: DW] = 16'hD000 + 16'(i);
            req_sel[i*SW +: SW]  = sel_of(i);
            req_we[i]            = 1'(i % 2);
        end
        RST = 1'b1; req_cyc = '0; req_stb = '0;
        o_ack = 1'b0; o_err = 1'b0; o_stall = 1'b0;

        // Round-robin handover: 0,1,2,3,0, one transaction each, two-cycle o_cyc gap.
        tbl.push_back(mk(1, 4'hF, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));
        for (int i = 0; i < 5; i++) begin
            m = 4'(1 << ord[i]);
            tbl.push_back(mk(0, 4'hF, m, 0, 0, 0, 1, 1, 4'h0, 4'h0, ~m, ord[i]));
            tbl.push_back(mk(0, 4'hF, 4'h0, 1, 0, 0, 1, 0, m, 4'h0, ~m, ord[i]));
            tbl.push_back(mk(0, 4'hF & ~m, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, ~m, ord[i]));
            tbl.push_back(mk(0, (i == 4) ? 4'h0 : 4'hF, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));
        end

        // Owner 2 pipelines writes up to MAXOUT; acks reopen one slot each; err and stray ack.
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 4'h6, 4'h4, 0, 0, 0, 1, 1, 4'h0, 4'h0, 4'hB, 2));
        tbl.push_back(mk(0, 4'h6, 4'h4, 1, 0, 0, 1, 0, 4'h4, 4'h0, 4'hF, 2));
        tbl.push_back(mk(0, 4'h6, 4'h4, 0, 0, 0, 1, 1, 4'h0, 4'h0, 4'hB, 2));
        tbl.push_back(mk(0, 4'h6, 4'h0, 1, 0, 0, 1, 0, 4'h4, 4'h0, 4'hF, 2));
        tbl.push_back(mk(0, 4'h6, 4'h0, 1, 0, 0, 1, 0, 4'h4, 4'h0, 4'hB, 2));
        tbl.push_back(mk(0, 4'h6, 4'h4, 1, 0, 0, 1, 1, 4'h4, 4'h0, 4'hB, 2));
        tbl.push_back(mk(0, 4'h6, 4'h0, 0, 1, 0, 1, 0, 4'h0, 4'h4, 4'hB, 2));
        tbl.push_back(mk(0, 4'h6, 4'h0, 1, 0, 0, 1, 0, 4'h0, 4'h0, 4'hB, 2));
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hB, 2));
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'hD, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hD, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));

        repeat (2) @(posedge CLK);
        #1;
        foreach (tbl[i]) apply(tbl[i]);

        // Watchdog: owner 3 gets one accept and no ack; ABORT follows the count reaching 8.
        apply(mk(0, 4'h9, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));
        apply(mk(0, 4'h9, 4'h8, 0, 0, 0, 1, 1, 4'h0, 4'h0, 4'h7, 3));
        for (int i = 0; i < 9; i++)
            apply(mk(0, 4'h9, 4'h0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h7, 3));
        apply(mk(0, 4'h9, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h8, 4'hF, -1));
        apply(mk(0, 4'h9, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));
        apply(mk(0, 4'h9, 4'h0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'hE, 0));
        apply(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hE, 0));
        apply(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));

        // Reset mid-BUSY with three outstanding; requester 0 regains priority afterwards.
        apply(mk(0, 4'h1, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));
        apply(mk(0, 4'h1, 4'h1, 0, 0, 1, 1, 1, 4'h0, 4'h0, 4'hF, 0));
        for (int i = 0; i < 3; i++)
            apply(mk(0, 4'h1, 4'h1, 0, 0, 0, 1, 1, 4'h0, 4'h0, 4'hE, 0));
        apply(mk(1, 4'h1, 4'h1, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'hF, 0));
        apply(mk(0, 4'h3, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));
        apply(mk(0, 4'h3, 4'h1, 0, 0, 0, 1, 1, 4'h0, 4'h0, 4'hE, 0));
        apply(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hE, 0));
        apply(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, -1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
